// File: rtl/serial_sub_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM encoding and default width.
package serial_sub_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/serial_sub_fs.sv
// 1-bit full subtractor cell: d = a - b - bin, bout set when the bit borrows.
module serial_sub_fs (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_sub.sv
// Bit-serial a - b - bin, LSB first, one bit per clock through a single
// full-subtractor cell and a borrow flop; results held until the next done.
module serial_sub
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf,
  output logic             zero
);

  // Handshake: start is only looked at while busy=0; an accepted start
  // raises busy until the cycle after the one-cycle done pulse.
  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-2:0] diff_sh;
  logic             brw;
  logic [CNT_W-1:0] count;
  logic             a_msb;
  logic             b_msb;

  logic             cell_d;
  logic             cell_bout;
  logic [WIDTH-1:0] diff_next;

  serial_sub_fs fs (
    .a   (a_sh[0]),
    .b   (b_sh[0]),
    .bin (brw),
    .d   (cell_d),
    .bout(cell_bout)
  );

  // Partial result so far with this cycle's bit entering at the MSB.
  assign diff_next = {cell_d, diff_sh};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      a_sh    <= '0;
      b_sh    <= '0;
      diff_sh <= '0;
      brw     <= 1'b0;
      count   <= '0;
      a_msb   <= 1'b0;
      b_msb   <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      diff    <= '0;
      bout    <= 1'b0;
      ovf     <= 1'b0;
      zero    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          busy <= 1'b0;
          if (start) begin
            a_sh  <= a;
            b_sh  <= b;
            brw   <= bin;
            a_msb <= a[WIDTH-1];
            b_msb <= b[WIDTH-1];
            count <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          a_sh    <= a_sh >> 1;
          b_sh    <= b_sh >> 1;
          diff_sh <= diff_next[WIDTH-1:1];
          brw     <= cell_bout;
          count   <= count + 1'b1;
          if (count == CNT_W'(WIDTH - 1)) begin
            // Last bit: publish into the frozen result registers.
            diff  <= diff_next;
            bout  <= cell_bout;
            ovf   <= (a_msb != b_msb) && (cell_d != a_msb);
            zero  <= (diff_next == '0);
            done  <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_sub.sv
// Directed bench for serial_sub (WIDTH=8): arithmetic vectors, latency,
// start-while-busy, result hold and asynchronous reset mid-operation.
module tb_serial_sub;

  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         bin;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         bout;
  logic         ovf;
  logic         zero;

  int checks     = 0;
  int failures   = 0;
  int stable_err = 0;
  logic [W-1:0] last_diff = '0;

  // Scoreboard entry: {diff, bout, ovf, zero}
  logic [W+2:0] exp_q[$];

  serial_sub #(.WIDTH(W)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .start(start),
    .a    (a),
    .b    (b),
    .bin  (bin),
    .busy (busy),
    .done (done),
    .diff (diff),
    .bout (bout),
    .ovf  (ovf),
    .zero (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [W-1:0] op_a, input logic [W-1:0] op_b,
                       input logic op_bin, input logic [W+2:0] e);
    @(negedge clk);
    a     = op_a;
    b     = op_b;
    bin   = op_bin;
    start = 1'b1;
    exp_q.push_back(e);
  endtask

  // drop_at=0 keeps start high and scrambles operands every cycle.
  task automatic wait_done(input int drop_at, output int lat);
    bit got = 1'b0;
    lat = 0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk);
      #1;
      if (done) begin
        got = 1'b1;
        lat = k;
        break;
      end
      if (diff !== last_diff) stable_err++;
      if (k == drop_at) start = 1'b0;
      if (drop_at == 0) begin
        a   = W'($urandom_range(0, 255));
        b   = W'($urandom_range(0, 255));
        bin = 1'($urandom_range(0, 1));
      end
    end
    check("done_seen", 32'(got), 32'd1);
  endtask

  task automatic check_result(input string tag);
    logic [W+2:0] e;
    if (exp_q.size() == 0) begin
      check({tag, "_exp_q_empty"}, 32'(exp_q.size()), 32'd1);
      return;
    end
    e = exp_q.pop_front();
    check({tag, "_diff"}, 32'(diff), 32'(e[W+2:3]));
    check({tag, "_bout"}, 32'(bout), 32'(e[2]));
    check({tag, "_ovf"},  32'(ovf),  32'(e[1]));
    check({tag, "_zero"}, 32'(zero), 32'(e[0]));
    check({tag, "_busy"}, 32'(busy), 32'd1);
    last_diff = e[W+2:3];
  endtask

  task automatic post_done(input string tag);
    @(posedge clk);
    #1;
    check({tag, "_done_pulse"}, 32'(done), 32'd0);
    check({tag, "_idle_busy"},  32'(busy), 32'd0);
    check({tag, "_diff_held"},  32'(diff), 32'(last_diff));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_diff"}, 32'(diff), 32'd0);
    check({tag, "_bout"}, 32'(bout), 32'd0);
    check({tag, "_ovf"},  32'(ovf),  32'd0);
    check({tag, "_zero"}, 32'(zero), 32'd0);
  endtask

  logic [W-1:0] va[6];
  logic [W-1:0] vb[6];
  logic         vbin[6];
  logic [W+2:0] vexp[6];

  initial begin
    int lat;

    // Hand-computed vectors: {diff, bout, ovf, zero}
    va[0] = 8'h05; vb[0] = 8'h03; vbin[0] = 1'b0; vexp[0] = {8'h02, 1'b0, 1'b0, 1'b0};
    va[1] = 8'h03; vb[1] = 8'h05; vbin[1] = 1'b0; vexp[1] = {8'hFE, 1'b1, 1'b0, 1'b0};
    va[2] = 8'h80; vb[2] = 8'h01; vbin[2] = 1'b0; vexp[2] = {8'h7F, 1'b0, 1'b1, 1'b0};
    va[3] = 8'h7F; vb[3] = 8'hFF; vbin[3] = 1'b0; vexp[3] = {8'h80, 1'b1, 1'b1, 1'b0};
    va[4] = 8'h00; vb[4] = 8'h00; vbin[4] = 1'b1; vexp[4] = {8'hFF, 1'b1, 1'b0, 1'b0};
    va[5] = 8'h2A; vb[5] = 8'h2A; vbin[5] = 1'b0; vexp[5] = {8'h00, 1'b0, 1'b0, 1'b1};

    // Clock/reset
    rst_n = 1'b0;
    start = 1'b0;
    a     = '0;
    b     = '0;
    bin   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 6; i++) begin
      issue(va[i], vb[i], vbin[i], vexp[i]);
      wait_done(1, lat);
      check($sformatf("vec%0d_latency", i), 32'(lat), 32'd9);
      check_result($sformatf("vec%0d", i));
      post_done($sformatf("vec%0d", i));
    end

    // start held high with changing operands while busy
    issue(8'h05, 8'h03, 1'b0, {8'h02, 1'b0, 1'b0, 1'b0});
    wait_done(0, lat);
    check("hold_latency", 32'(lat), 32'd9);
    check_result("hold");
    a   = 8'h10;
    b   = 8'h01;
    bin = 1'b0;
    exp_q.push_back({8'h0F, 1'b0, 1'b0, 1'b0});
    @(posedge clk);
    #1;
    check("hold_gap_done", 32'(done), 32'd0);
    check("hold_gap_busy", 32'(busy), 32'd0);
    check("hold_gap_diff", 32'(diff), 32'h02);
    wait_done(1, lat);
    check("chain_latency", 32'(lat), 32'd9);
    check_result("chain");
    post_done("chain");

    // Asynchronous reset in RUN cycle 4
    @(negedge clk);
    a     = 8'h33;
    b     = 8'h11;
    bin   = 1'b0;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("async_rst");
    @(posedge clk);
    #1;
    check_all_zero("rst_held");
    @(negedge clk);
    rst_n     = 1'b1;
    last_diff = '0;
    issue(8'h5A, 8'h12, 1'b1, {8'h47, 1'b0, 1'b0, 1'b0});
    wait_done(1, lat);
    check("after_rst_latency", 32'(lat), 32'd9);
    check_result("after_rst");
    post_done("after_rst");

    check("diff_hold_violations", 32'(stable_err), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/serial_sub.md
Name: serial_sub

Overview:
- Bit-serial WIDTH-bit subtractor computing a - b - bin, LSB first, one bit per clock.
- Inverse-direction companion to the combinational full adder.
- Built around a single 1-bit full-subtractor cell plus a borrow flip-flop.
- Serves area-constrained datapaths that can accept WIDTH-cycle latency; start/busy/done handshake toward the controlling FSM.

Parameters:
- WIDTH, 8, operand and result width in bits (legal range 2..32).
- CNT_W, $clog2(WIDTH+1), bit-counter width (derived; do not override).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request; sampled only in IDLE.
- a  input  WIDTH  minuend; captured on accepted start.
- b  input  WIDTH  subtrahend; captured on accepted start.
- bin  input  1  borrow-in; captured on accepted start.
- busy  output  1  high while an operation is in progress (RUN or DONE).
- done  output  1  one-cycle pulse; results valid from this cycle.
- diff  output  WIDTH  a - b - bin, modulo 2^WIDTH.
- bout  output  1  unsigned borrow-out (1 when a < b + bin).
- ovf  output  1  signed two's-complement overflow.
- zero  output  1  diff == 0.

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values: state=IDLE, busy=0, done=0, diff=0, bout=0, ovf=0, zero=0, count=0, internal shift registers and borrow flop cleared.
- IDLE: busy=0. If start=1, capture a, b and bin (bin loads the borrow flop), set count=0, go to RUN.
- RUN: busy=1, once per cycle:
  - The cell computes d = a_sh[0] ^ b_sh[0] ^ brw and brw_next = (~a_sh[0] & b_sh[0]) | (~(a_sh[0] ^ b_sh[0]) & brw).
  - a_sh and b_sh shift right; d shifts into the MSB of the diff shift register; brw <= brw_next; count++.
  - When count reaches WIDTH-1 (the last bit is processed this cycle), go to DONE.
- DONE: busy=1, done=1 for exactly one cycle. Then return to IDLE.
  - diff holds the full result; bout = final borrow.
  - ovf = (a_msb != b_msb) && (diff_msb != a_msb), using the captured operand MSBs.
  - zero = (diff == 0).
- Latency: start accepted at edge N, then WIDTH RUN cycles, then done high in the cycle after edge N+WIDTH (done asserted WIDTH+1 cycles after start sampled).
- Throughput: a new start is accepted in the IDLE cycle following DONE. Back-to-back issue period is WIDTH+2 cycles.
- Result hold: diff/bout/ovf/zero hold their DONE values until the next DONE; they do not change during a subsequent RUN. This requires a separate result register or a freeze on the output copy.
- start while busy=1: ignored entirely; no capture, no queueing.
- Operand changes after capture: no effect on the operation in progress.
- Reset mid-operation: immediate return to reset values; no done pulse; partial result discarded.
- No combinational path from inputs to outputs; all outputs are registered.

Decomposition:
- Shared package: state encoding constants (IDLE=2'd0, RUN=2'd1, DONE=2'd2) and the default WIDTH.
- Sub-module: fs, a 1-bit full subtractor (inputs a, b, bin; outputs d, bout), purely combinational, instantiated once.

Test Plan:
- WIDTH=8, a=0x05, b=0x03, bin=0 -> diff=0x02, bout=0, ovf=0, zero=0; done exactly 9 cycles after start sampled.
- a=0x03, b=0x05, bin=0 -> diff=0xFE, bout=1, ovf=0, zero=0.
- a=0x80, b=0x01, bin=0 -> diff=0x7F, bout=0, ovf=1. Also a=0x7F, b=0xFF -> diff=0x80, bout=1, ovf=1.
- a=0x00, b=0x00, bin=1 -> diff=0xFF, bout=1, zero=0. Also a=0x2A, b=0x2A, bin=0 -> diff=0x00, zero=1, bout=0.
- start held high with changing operands during RUN -> exactly one done pulse, result from the first captured operands; the next op is accepted only after returning to IDLE; outputs stable between dones.
- rst_n pulsed low at RUN cycle 4 -> all outputs 0 asynchronously, no done pulse; a fresh op after release gives the correct result.
